line_window_gen: RTL
====================

// Module: line_window_gen
// PURPOSE
//  Parametrised KSIZE x KSIZE sliding-window generator for the edge-detection pipeline.
//  Takes a raster pixel stream with a valid strobe. Stores KSIZE-1 previous lines in
//  circular line memories and emits the full window every accepted pixel.
//  Sits between the pixel source and the Sobel/convolution stage, and replaces the fixed
//  3-tap shift-register line buffer with stall support, frame counters and window-valid
//  masking.
// PARAMETERS
//  BITSIZE  8    pixel width in bits
//  LENGTH   480  pixels per line (>= KSIZE)
//  ROWS     320  lines per frame (>= KSIZE)
//  KSIZE    3    window edge; odd, 3..7
// PORTS
//  clk        in   1                    single clock, all logic on posedge
//  rst        in   1                    synchronous, active-low reset
//  in_valid   in   1                    pixel strobe; no backpressure, consumer always accepts
//  in_pix     in   BITSIZE              raster pixel, row-major
//  in_sof     in   1                    start-of-frame marker (used only with SOF_SYNC_EN)
//  win_valid  out  1                    win_data holds a complete in-frame window
//  win_data   out  KSIZE*KSIZE*BITSIZE  tap t=r*KSIZE+c at [t*BITSIZE +: BITSIZE]; r=0 oldest row, c=0 oldest col
//  win_eol    out  1                    window's newest pixel is last of its line
//  win_eof    out  1                    window's newest pixel is last of the frame
// BEHAVIOUR
//  - Reset (rst==0 at posedge): col/row counters 0; win_valid, win_eol, win_eof 0; win_data all-zero.
//    Line memory contents are not reset; stale data is masked by win_valid.
//  - Accept: a pixel is accepted on a posedge with in_valid==1. With in_valid==0, no counter,
//    memory or window register changes, and win_valid drops to 0 the next cycle.
//  - Line memories L[0..KSIZE-2], LENGTH deep, share address = col.
//    Read-before-write on accept: rd[j]=L[j][col]; L[0][col]<=in_pix; L[j][col]<=rd[j-1].
//  - Window shift on accept: all columns move one step left.
//    New rightmost column = {rd[KSIZE-2],...,rd[0],in_pix}, top to bottom.
//  - Counters on accept: col++. At col==LENGTH-1, col<=0 and row++.
//    At row==ROWS-1 with col==LENGTH-1, row<=0 (frame wrap).
//  - Latency: 1 cycle. Outputs are registered on the edge after accept.
//  - win_valid=1 iff the accepted pixel had row>=KSIZE-1 and col>=KSIZE-1. This suppresses
//    left-edge windows spanning two lines and the first KSIZE-1 rows of every frame.
//  - Windows per frame = (LENGTH-KSIZE+1)*(ROWS-KSIZE+1).
//  - win_eol=1 with accepted col==LENGTH-1.
//  - win_eof=1 with accepted col==LENGTH-1 and row==ROWS-1.
//  - Both flags are qualified by the same accept, not by win_valid.
//  - Reset mid-frame: the next frame starts at (0,0). No window is emitted until (KSIZE-1,KSIZE-1).
// CONFIGURATION
//  SOF_SYNC_EN defined:
//   - in_sof==1 with in_valid==1 forces the pixel to be treated as (0,0). Counters then
//     advance from there, and earlier partial-frame state is discarded by the masking.
//   - in_sof with in_valid==0 is ignored.
//   - in_sof on a pixel already at (0,0) is a no-op.
//  SOF_SYNC_EN undefined:
//   - in_sof is ignored. Framing comes from the counters and ROWS only.
// STRUCTURE
//  Shared package line_window_pkg:
//   - counter widths COL_W=$clog2(LENGTH), ROW_W=$clog2(ROWS)
//   - tap index function tap_idx(r,c)=r*KSIZE+c
//   - KSIZE legality check constant
//  Sub-module line_ram:
//   - BITSIZE x LENGTH, single port, synchronous-write / read-before-write
//   - instantiated KSIZE-2+1 times via generate
//   - must infer BRAM at LENGTH>=256
// TESTING  (bench: LENGTH=8, ROWS=6, KSIZE=3, pixel value = row*16+col)
//  1. Continuous ramp frame -> first win_valid 1 cycle after accepting 0x22.
//     Taps t0..t8 = 00,01,02,10,11,12,20,21,22. Exactly 24 windows per frame.
//  2. Same ramp, in_valid random 50% duty -> identical window sequence.
//     win_valid never high in a cycle following in_valid==0.
//  3. Accept 0x57 -> win_eol=1, win_eof=1 and window taps 35..57.
//     Next frame pixels (0,*) and (1,*) produce win_valid=0.
//  4. Reset asserted while accepting pixel (3,4) -> next cycle all outputs 0.
//     After release, new ramp gives first window at 0x22 with the same taps as scenario 1.
//  5. SOF_SYNC_EN: in_sof with pixel (1,5) -> counters restart.
//     First window follows the 19th pixel after sof; undefined build -> sof ignored, 24 windows as normal.
//  6. KSIZE=5, LENGTH=8, ROWS=6 -> first window after pixel 0x44; taps t0=0x00, t24=0x44; 8 windows per frame.

Source files
------------

// File: rtl/line_window_pkg.sv
// Shared constants and helpers for the KSIZE x KSIZE line-window generator.
// Counter widths are derived from the top-level parameters through cnt_w().
package line_window_pkg;

    localparam int unsigned KSIZE_MIN = 3;
    localparam int unsigned KSIZE_MAX = 7;

    // Flat tap index of window element (r, c); r=0 is the oldest row, c=0 the oldest column.
    function automatic int unsigned tap_idx(input int unsigned r, input int unsigned c,
                                            input int unsigned k);
        return r * k + c;
    endfunction

    // Window edge must be odd and within the supported range.
    function automatic bit ksize_legal(input int unsigned k);
        return (k >= KSIZE_MIN) && (k <= KSIZE_MAX) && (k % 2 == 1);
    endfunction

    // Counter width for a count of n positions (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/line_window_gen_line_ram.sv
// One line memory: BITSIZE x LENGTH, synchronous write and registered read.
// The read address is driven with the next column so the registered output
// already holds L[col] when that pixel arrives (read-before-write at col).
module line_ram #(
    parameter int unsigned BITSIZE = 8,
    parameter int unsigned LENGTH  = 480,
    parameter int unsigned AW      = 9
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [AW-1:0]      wr_addr_i,
    input  logic [BITSIZE-1:0] wr_data_i,
    input  logic [AW-1:0]      rd_addr_i,
    output logic [BITSIZE-1:0] rd_data_o
);

    logic [BITSIZE-1:0] mem_q [LENGTH];
    logic [BITSIZE-1:0] rd_q;

    // Plain write plus registered read, the template block RAMs map onto.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/line_window_gen.sv
// KSIZE x KSIZE sliding-window generator over a raster pixel stream.
// KSIZE-1 circular line memories hold the previous lines; one window per
// accepted pixel, registered one cycle after accept and masked by win_valid.
// Optional feature: define SOF_SYNC_EN to let in_sof force the pixel to (0,0).
module line_window_gen
    import line_window_pkg::*;
#(
    parameter int unsigned BITSIZE = 8,
    parameter int unsigned LENGTH  = 480,
    parameter int unsigned ROWS    = 320,
    parameter int unsigned KSIZE   = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [BITSIZE-1:0]               in_pix,
    input  logic                             in_sof,
    output logic                             win_valid,
    output logic [KSIZE*KSIZE*BITSIZE-1:0]   win_data,
    output logic                             win_eol,
    output logic                             win_eof
);

    localparam int unsigned COL_W  = cnt_w(LENGTH);
    localparam int unsigned ROW_W  = cnt_w(ROWS);
    localparam int unsigned NLINES = KSIZE - 1;
    localparam int unsigned NTAPS  = KSIZE * KSIZE;

    if (!ksize_legal(KSIZE) || (LENGTH < KSIZE) || (ROWS < KSIZE)) begin : g_bad_param
        $error("line_window_gen: illegal KSIZE/LENGTH/ROWS combination");
    end

    logic [COL_W-1:0] col_q, col_d, col_cur;
    logic [ROW_W-1:0] row_q, row_d, row_cur;
    logic             sof_hit;
    logic             last_col, last_row;
    logic             valid_d;

    logic [NTAPS-1:0][BITSIZE-1:0]  win_q, win_d;
    logic [NLINES-1:0][BITSIZE-1:0] rd;
    logic                           valid_q, eol_q, eof_q;

`ifdef SOF_SYNC_EN
    assign sof_hit = in_valid & in_sof;
`else
    logic unused_sof;
    assign unused_sof = in_sof;
    assign sof_hit    = 1'b0;
`endif

    // Position of the pixel being presented; a start-of-frame pixel counts as (0,0).
    assign col_cur  = sof_hit ? '0 : col_q;
    assign row_cur  = sof_hit ? '0 : row_q;
    assign last_col = (col_cur == COL_W'(LENGTH - 1));
    assign last_row = (row_cur == ROW_W'(ROWS - 1));
    assign valid_d  = in_valid && (row_cur >= ROW_W'(KSIZE - 1)) && (col_cur >= COL_W'(KSIZE - 1));

    // Next raster position; also drives the line-memory prefetch address, so reset forces 0.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (!rst) begin
            col_d = '0;
            row_d = '0;
        end else if (in_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
                row_d = row_cur;
            end
        end
    end

    for (genvar j = 0; j < NLINES; j++) begin : g_line
        logic [BITSIZE-1:0] wr_data;
        if (j == 0) begin : g_first
            assign wr_data = in_pix;
        end else begin : g_chain
            assign wr_data = rd[j-1];
        end
        line_ram #(
            .BITSIZE (BITSIZE),
            .LENGTH  (LENGTH),
            .AW      (COL_W)
        ) u_line_ram (
            .clk       (clk),
            .we_i      (in_valid & rst),
            .wr_addr_i (col_cur),
            .wr_data_i (wr_data),
            .rd_addr_i (col_d),
            .rd_data_o (rd[j])
        );
    end

    // Shift every window column left; the new rightmost column is the line reads over in_pix.
    always_comb begin
        win_d = win_q;
        if (in_valid) begin
            for (int unsigned r = 0; r < KSIZE; r++) begin
                for (int unsigned c = 0; c + 1 < KSIZE; c++) begin
                    win_d[tap_idx(r, c, KSIZE)] = win_q[tap_idx(r, c + 1, KSIZE)];
                end
            end
            for (int unsigned r = 0; r < NLINES; r++) begin
                win_d[tap_idx(r, KSIZE - 1, KSIZE)] = rd[NLINES - 1 - r];
            end
            win_d[tap_idx(KSIZE - 1, KSIZE - 1, KSIZE)] = in_pix;
        end
    end

    // Counters, window and flags registered together; flags follow the accept, not win_valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            eol_q   <= in_valid & last_col;
            eof_q   <= in_valid & last_col & last_row;
        end
    end

    assign win_valid = valid_q;
    assign win_data  = win_q;
    assign win_eol   = eol_q;
    assign win_eof   = eof_q;

endmodule
